// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA raster path.
package vga_pkg;

  // Default 640x480@60 horizontal timing (pixel clocks)
  localparam int unsigned HVID  = 640;
  localparam int unsigned HFP   = 16;
  localparam int unsigned HSYNC = 96;
  localparam int unsigned HBP   = 48;

  // Default 640x480@60 vertical timing (lines)
  localparam int unsigned VVID  = 480;
  localparam int unsigned VFP   = 10;
  localparam int unsigned VSYNC = 2;
  localparam int unsigned VBP   = 33;

  // Derived totals for the default mode
  localparam int unsigned HTOTAL = HVID + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VVID + VFP + VSYNC + VBP;

  // Coordinate width and the largest total it can represent
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TOTAL = 1 << COORD_W;

  // Sync bundle handed to the colour generators
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 while enabled and
// resets to the terminal value so the first enabled edge lands on 0.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned W     = COORD_W,
  parameter int unsigned TOTAL = HTOTAL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next_c,
  output logic         tc_c
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  // Terminal count: this axis wraps on the next enabled edge
  assign tc_c = (count == LAST);

  // Next value: hold, increment, or wrap to zero
  always_comb begin
    count_next_c = count;
    if (en) begin
      count_next_c = tc_c ? '0 : count + W'(1);
    end
  end

  // Count register, parked on the terminal value in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA pixel-coordinate interface.
// Optional build macro VGA_SYNC_DELAY_EN adds one pixel_en-gated register
// stage on hsync/vsync/video_on/load_enable to line them up with a colour
// stage that registers RGB one cycle after sampling the coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned HVID  = vga_pkg::HVID,
  parameter int unsigned HFP   = vga_pkg::HFP,
  parameter int unsigned HSYNC = vga_pkg::HSYNC,
  parameter int unsigned HBP   = vga_pkg::HBP,
  parameter int unsigned VVID  = vga_pkg::VVID,
  parameter int unsigned VFP   = vga_pkg::VFP,
  parameter int unsigned VSYNC = vga_pkg::VSYNC,
  parameter int unsigned VBP   = vga_pkg::VBP
) (
  input  logic               clk_25,
  input  logic               rst_n,
  input  logic               pixel_en,
  output logic [COORD_W-1:0] horizontal_num,
  output logic [COORD_W-1:0] vertical_num,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               load_enable,
  output logic               frame_start,
  output logic               line_end
);

  localparam int unsigned H_TOTAL = HVID + HFP + HSYNC + HBP;
  localparam int unsigned V_TOTAL = VVID + VFP + VSYNC + VBP;

  // One spare bit so region ends equal to the total (1024) still compare
  localparam int unsigned CMP_W = COORD_W + 1;

  localparam logic [CMP_W-1:0] H_VID_END    = CMP_W'(HVID);
  localparam logic [CMP_W-1:0] H_SYNC_START = CMP_W'(HVID + HFP);
  localparam logic [CMP_W-1:0] H_SYNC_END   = CMP_W'(HVID + HFP + HSYNC);
  localparam logic [CMP_W-1:0] V_VID_END    = CMP_W'(VVID);
  localparam logic [CMP_W-1:0] V_SYNC_START = CMP_W'(VVID + VFP);
  localparam logic [CMP_W-1:0] V_SYNC_END   = CMP_W'(VVID + VFP + VSYNC);
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);

  // Refuse to elaborate a mode whose totals overflow the coordinate width
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
    $error("vga_timing_gen: HTOTAL/VTOTAL exceed coordinate range");
  end

  logic [COORD_W-1:0] h_next_c;
  logic [COORD_W-1:0] v_next_c;
  logic               h_tc_c;
  logic               v_tc_c;
  logic               v_en_c;
  logic [CMP_W-1:0]   h_ext_c;
  logic [CMP_W-1:0]   v_ext_c;

  sync_t sync_next_c;
  logic  frame_start_next_c;
  logic  line_end_next_c;

  sync_t sync_q;
  logic  blank_q;

  // Vertical axis steps only on the horizontal wrap
  assign v_en_c = pixel_en & h_tc_c;

  vga_axis_counter #(
    .W     (COORD_W),
    .TOTAL (H_TOTAL)
  ) u_h_cnt (
    .clk          (clk_25),
    .rst_n        (rst_n),
    .en           (pixel_en),
    .count        (horizontal_num),
    .count_next_c (h_next_c),
    .tc_c         (h_tc_c)
  );

  vga_axis_counter #(
    .W     (COORD_W),
    .TOTAL (V_TOTAL)
  ) u_v_cnt (
    .clk          (clk_25),
    .rst_n        (rst_n),
    .en           (v_en_c),
    .count        (vertical_num),
    .count_next_c (v_next_c),
    .tc_c         (v_tc_c)
  );

  // Decode the position the counters are about to present
  always_comb begin
    sync_next_c        = SYNC_IDLE;
    frame_start_next_c = 1'b0;
    line_end_next_c    = 1'b0;

    h_ext_c = {1'b0, h_next_c};
    v_ext_c = {1'b0, v_next_c};

    sync_next_c.video_on = (h_ext_c < H_VID_END) && (v_ext_c < V_VID_END);
    sync_next_c.hsync    = !((h_ext_c >= H_SYNC_START) && (h_ext_c < H_SYNC_END));
    sync_next_c.vsync    = !((v_ext_c >= V_SYNC_START) && (v_ext_c < V_SYNC_END));

    // (0,0) is only ever reached by the joint wrap out of the last pixel
    frame_start_next_c   = v_en_c & v_tc_c;
    line_end_next_c      = (h_next_c == H_LAST);
  end

  // Output registers, aligned with the counter registers
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= SYNC_IDLE;
      blank_q     <= 1'b1;
      frame_start <= 1'b0;
      line_end    <= 1'b1;
    end else if (pixel_en) begin
      sync_q      <= sync_next_c;
      blank_q     <= ~sync_next_c.video_on;
      frame_start <= frame_start_next_c;
      line_end    <= line_end_next_c;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  sync_t sync_dly_q;
  logic  blank_dly_q;

  // Extra stage so sync/blanking track the registered colour pipeline
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync_dly_q  <= SYNC_IDLE;
      blank_dly_q <= 1'b1;
    end else if (pixel_en) begin
      sync_dly_q  <= sync_q;
      blank_dly_q <= blank_q;
    end
  end

  assign hsync       = sync_dly_q.hsync;
  assign vsync       = sync_dly_q.vsync;
  assign video_on    = sync_dly_q.video_on;
  assign load_enable = blank_dly_q;
`else
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign video_on    = sync_q.video_on;
  assign load_enable = blank_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA path, clocked by the 25 MHz pixel clock. Produces horizontal/vertical pixel coordinates, sync pulses and the blanking strobe that the colour generators consume. Colour generators sample `horizontal_num`/`vertical_num` and force black while `load_enable` is high. This block is the driving end of that pixel-coordinate interface.

## Interface
- HVID, 640, visible pixels per line
- HFP, 16, horizontal front porch (clocks)
- HSYNC, 96, horizontal sync width (clocks)
- HBP, 48, horizontal back porch (clocks)
- VVID, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vertical sync width (lines)
- VBP, 33, vertical back porch (lines)
- clk_25  in  1  pixel clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- pixel_en  in  1  count enable; low freezes all state and outputs
- horizontal_num  out  10  current column, 0..HTOTAL-1
- vertical_num  out  10  current line, 0..VTOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high inside visible area
- load_enable  out  1  blanking strobe, always equal to ~video_on
- frame_start  out  1  one-cycle pulse at (0,0)
- line_end  out  1  one-cycle pulse at h = HTOTAL-1

## Operation
- HTOTAL = HVID+HFP+HSYNC+HBP (800); VTOTAL = VVID+VFP+VSYNC+VBP (525). Both must be ≤ 1024; elaborate-time assertion otherwise.
- Horizontal counter: advances by 1 per enabled clock. At HTOTAL-1 it wraps to 0 and the vertical counter advances.
- Vertical counter: wraps from VTOTAL-1 to 0 only on the same edge as the horizontal wrap. The simultaneous wrap at (HTOTAL-1, VTOTAL-1) yields (0,0) in one edge.
- Decode from the next-state counter values; all outputs are registered, with no combinational paths to outputs.
  - video_on = (h < HVID) && (v < VVID).
  - hsync = 0 iff HVID+HFP ≤ h < HVID+HFP+HSYNC, i.e. [656,752).
  - vsync = 0 iff VVID+VFP ≤ v < VVID+VFP+VSYNC, i.e. [490,492).
  - frame_start = (h==0 && v==0).
  - line_end = (h==HTOTAL-1).
- Reset state represents position (HTOTAL-1, VTOTAL-1):
  - horizontal_num=799, vertical_num=524
  - hsync=1, vsync=1, video_on=0, load_enable=1
  - frame_start=0, line_end=1
  - The first enabled edge after release therefore presents pixel (0,0) with video_on=1 and frame_start=1.
- pixel_en low: counters and every output hold their values. Wrap and pulse outputs do not repeat or extend beyond the enabled cycle that produced them.
- Reset mid-frame: outputs return asynchronously to the reset state above. Counting restarts at (0,0) on the first enabled edge after deassertion.

## Timing
- Latency 0: every output corresponds to the horizontal_num/vertical_num presented in the same cycle.
- One line = HTOTAL enabled clocks; one frame = HTOTAL*VTOTAL = 420000 enabled clocks.
- hsync low for exactly HSYNC consecutive enabled clocks per line.
- vsync low for exactly VSYNC*HTOTAL enabled clocks. It asserts on the edge where h=0, v=490.

## Configuration
- VGA_SYNC_DELAY_EN defined:
  - hsync, vsync, video_on and load_enable pass through one extra register stage, enabled by pixel_en. This aligns them with a downstream colour stage that registers RGB one cycle after sampling coordinates.
  - horizontal_num, vertical_num, frame_start and line_end are not delayed.
  - The delay stage resets to hsync=1, vsync=1, video_on=0, load_enable=1.
- VGA_SYNC_DELAY_EN undefined: the behaviour described above, with no delay stage.

## Structure
- Shared package vga_pkg holds:
  - default 640x480 timing constants (HVID…VBP)
  - derived HTOTAL/VTOTAL
  - coordinate width constant (10)
  - a packed struct typedef for the sync bundle {hsync, vsync, video_on}
- One sub-module, vga_axis_counter: parameterised wrap counter with enable and a terminal-count output.
  - Instantiated twice: horizontal, and vertical with enable = pixel_en && h terminal count.

## Test plan
- Reset asserted then released, pixel_en=1 → before the first edge, (799,524), load_enable=1, line_end=1. After the first edge: (0,0), video_on=1, frame_start=1.
- Run one line → hsync falls on the edge to h=656 and rises on the edge to h=752; video_on falls at h=640; line_end high only at h=799.
- Run a full frame → vsync low for exactly 1600 clocks starting at (0,490); frame_start recurs after exactly 420000 clocks; both counters wrap on the same edge.
- Toggle pixel_en low for 7 cycles at h=655 → all outputs frozen; hsync falls on the first enabled edge afterwards; no duplicate line_end pulse.
- Assert rst_n low asynchronously at (300,200) mid-clock → outputs go to the reset state immediately without waiting for an edge; after release the count restarts at (0,0).
- With VGA_SYNC_DELAY_EN defined → hsync falls at h=657; video_on falls at h=641; coordinate outputs unchanged.
